alarm_sequencer: RTL and testbench
==================================

Name: alarm_sequencer

Overview:
Controls the alarm path of the digital clock. It compares the running BCD time against the stored BCD alarm time, sequences the ring / snooze / dismiss cycle, and drives a pulsed BUZZER pattern. It sits between the clock counter (time and alarm digits) and the BUZZER pin. It also owns the ring timeout and the snooze timing.

Parameters:
CLK_HZ, 50000000, CLOCK_50 cycles per internal 1 s tick
BEEP_HALF, 12500000, cycles per BUZZER on-phase and per off-phase while ringing (250 ms)
RING_SEC, 60, seconds of unanswered ringing before auto-dismiss
SNOOZE_SEC, 300, seconds spent in snooze before re-ring
MAX_SNOOZE, 3, snoozes allowed per alarm event; the next SNOOZE acts as dismiss
CHIME_CYC, 5000000, hourly chime pulse length in cycles (optional feature only)

Ports:
CLOCK_50  in  1  system clock
RESET  in  1  synchronous, active-high reset
ALARM_ON  in  1  alarm enable level (switch)
SET_ALARM  in  1  alarm-edit mode level; suppresses triggering
SNOOZE  in  1  one-cycle pulse, debounced upstream
DISMISS  in  1  one-cycle pulse, debounced upstream
HOUR_TEN, HOUR_ONE, MIN_TEN, MIN_ONE, SEC_TEN, SEC_ONE  in  4 each  current time, BCD
A_HOUR_TEN, A_HOUR_ONE, A_MIN_TEN, A_MIN_ONE  in  4 each  alarm time, BCD
BUZZER  out  1  buzzer drive, active-high
ALARM_STATE  out  2  0=OFF 1=ARMED 2=RINGING 3=SNOOZE
SNOOZE_CNT  out  2  snoozes taken in the current event

Behaviour:
- Reset: state OFF; BUZZER=0; SNOOZE_CNT=0; all counters 0; match history register = 1, so no trigger fires on the first cycle after reset.
- Reset overrides every other input in the same cycle.
- Tick: free-running 0..CLK_HZ-1 prescaler; one-cycle tick when it is at CLK_HZ-1.
- match = hours and minutes equal the alarm digits, and SEC_TEN=0 and SEC_ONE=0.
- trigger = match AND NOT match_d (registered) AND ALARM_ON AND NOT SET_ALARM. It fires once per minute boundary.
- Transition priority, highest first: RESET, ALARM_ON=0, SET_ALARM=1, DISMISS, SNOOZE, timers/trigger.
- Any state with ALARM_ON=0 -> OFF.
- OFF with ALARM_ON=1 -> ARMED.
- SET_ALARM=1 while RINGING or SNOOZE -> ARMED.
- ARMED: trigger -> RINGING. SNOOZE_CNT cleared; ring-second counter cleared; beep counter cleared.
- RINGING:
  - DISMISS -> ARMED.
  - SNOOZE with SNOOZE_CNT<MAX_SNOOZE -> SNOOZE; SNOOZE_CNT+1; snooze counter cleared.
  - SNOOZE with SNOOZE_CNT=MAX_SNOOZE -> ARMED.
  - Tick with ring counter = RING_SEC-1 -> ARMED (timeout).
  - Otherwise the ring counter increments on each tick.
  - DISMISS and SNOOZE in the same cycle: DISMISS wins.
- SNOOZE:
  - DISMISS -> ARMED.
  - Tick with snooze counter = SNOOZE_SEC-1 -> RINGING; ring and beep counters cleared.
  - SNOOZE pulses are ignored. Triggers are ignored.
- Re-entry into RINGING from snooze does not clear SNOOZE_CNT.
- SNOOZE_CNT saturates at MAX_SNOOZE and clears only on a new trigger or on reset.
- BUZZER is registered and updates on the same edge as ALARM_STATE.
  - In RINGING: beep counter wraps at 2*BEEP_HALF-1. BUZZER=1 for counts 0..BEEP_HALF-1, 0 otherwise. The first on-phase starts on the entry cycle.
  - In all other states: BUZZER=0, except the optional chime.
- The tick prescaler is never reset by state changes. The first ring/snooze second may therefore be short by up to one tick period.
- Inputs are in the CLOCK_50 domain. BCD inputs are trusted valid, and no range checking is done.

Optional Feature:
HOURLY_CHIME_EN
- Defined: in OFF or ARMED, a rising edge of (MIN_TEN=0 & MIN_ONE=0 & SEC_TEN=0 & SEC_ONE=0) drives BUZZER=1 for CHIME_CYC cycles. Suppressed while SET_ALARM=1. If a trigger coincides, RINGING takes over and the chime counter is cleared.
- Undefined: no chime logic and no chime counter exist. BUZZER is driven only in RINGING.

Test Plan:
Bench params: CLK_HZ=20, BEEP_HALF=5, RING_SEC=4, SNOOZE_SEC=3, MAX_SNOOZE=2.
- RESET with ALARM_ON=1 -> OFF, then ARMED the next cycle. Alarm 07:30 and time 07:30:00 present from reset -> no ringing.
- Time steps 07:29:59 -> 07:30:00 with alarm 07:30 -> RINGING on the next edge. BUZZER pattern is 5 cycles high / 5 low. Auto-return to ARMED after 4 ticks. Holding 07:30:00 does not retrigger.
- RINGING; SNOOZE pulse -> SNOOZE, SNOOZE_CNT=1, BUZZER=0. After 3 ticks -> RINGING. Second SNOOZE -> SNOOZE_CNT=2. Third SNOOZE while ringing -> ARMED.
- RINGING; SNOOZE and DISMISS in the same cycle -> ARMED, SNOOZE_CNT unchanged.
- SNOOZE state; drop ALARM_ON -> OFF and BUZZER=0 on the next edge. Set SET_ALARM=1 at the match minute -> no trigger.
- HOURLY_CHIME_EN defined, ARMED, time 08:59:59 -> 09:00:00 -> BUZZER high for exactly CHIME_CYC cycles. Macro undefined -> BUZZER stays 0.

Source files
------------

// File: rtl/alarm_sequencer_if.sv
// Signal bundle between the clock counter / buttons and the alarm sequencer.
// master drives time, alarm digits and controls; slave returns buzzer and status.
interface alarm_sequencer_if;
  logic       ALARM_ON;
  logic       SET_ALARM;
  logic       SNOOZE;
  logic       DISMISS;
  logic [3:0] HOUR_TEN;
  logic [3:0] HOUR_ONE;
  logic [3:0] MIN_TEN;
  logic [3:0] MIN_ONE;
  logic [3:0] SEC_TEN;
  logic [3:0] SEC_ONE;
  logic [3:0] A_HOUR_TEN;
  logic [3:0] A_HOUR_ONE;
  logic [3:0] A_MIN_TEN;
  logic [3:0] A_MIN_ONE;
  logic       BUZZER;
  logic [1:0] ALARM_STATE;
  logic [1:0] SNOOZE_CNT;

  modport master (
    output ALARM_ON, SET_ALARM, SNOOZE, DISMISS,
    output HOUR_TEN, HOUR_ONE, MIN_TEN, MIN_ONE, SEC_TEN, SEC_ONE,
    output A_HOUR_TEN, A_HOUR_ONE, A_MIN_TEN, A_MIN_ONE,
    input  BUZZER, ALARM_STATE, SNOOZE_CNT
  );

  modport slave (
    input  ALARM_ON, SET_ALARM, SNOOZE, DISMISS,
    input  HOUR_TEN, HOUR_ONE, MIN_TEN, MIN_ONE, SEC_TEN, SEC_ONE,
    input  A_HOUR_TEN, A_HOUR_ONE, A_MIN_TEN, A_MIN_ONE,
    output BUZZER, ALARM_STATE, SNOOZE_CNT
  );
endinterface

// File: rtl/alarm_sequencer.sv
// Alarm ring / snooze / dismiss sequencer with pulsed buzzer drive.
// Optional hourly chime is built only when HOURLY_CHIME_EN is defined.
//
// state   | meaning
// OFF     | alarm switch off, buzzer silent
// ARMED   | waiting for the alarm minute boundary
// RINGING | buzzer pulsing, ring timeout running
// SNOOZE  | silent, snooze timer running toward re-ring
module alarm_sequencer #(
  parameter int CLK_HZ     = 50000000,
  parameter int BEEP_HALF  = 12500000,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3,
  parameter int CHIME_CYC  = 5000000
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  alarm_sequencer_if.slave  bus
);

  localparam int PRE_W  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int BEEP_W = (2 * BEEP_HALF > 1) ? $clog2(2 * BEEP_HALF) : 1;
  localparam int RING_W = (RING_SEC > 1) ? $clog2(RING_SEC) : 1;
  localparam int SNZ_W  = (SNOOZE_SEC > 1) ? $clog2(SNOOZE_SEC) : 1;

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CLK_HZ - 1);
  localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(2 * BEEP_HALF - 1);
  localparam logic [BEEP_W-1:0] BEEP_ON   = BEEP_W'(BEEP_HALF);
  localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_SEC - 1);
  localparam logic [SNZ_W-1:0]  SNZ_LAST  = SNZ_W'(SNOOZE_SEC - 1);
  localparam logic [1:0]        SNZ_MAX   = 2'(MAX_SNOOZE);

  localparam logic [1:0] ST_OFF     = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_RINGING = 2'd2;
  localparam logic [1:0] ST_SNOOZE  = 2'd3;

  logic [PRE_W-1:0]  presc_q, presc_d;
  logic              match_hist_q, match_hist_d;
  logic [1:0]        state_q, state_d;
  logic [1:0]        snooze_cnt_q, snooze_cnt_d;
  logic [RING_W-1:0] ring_q, ring_d;
  logic [SNZ_W-1:0]  snz_q, snz_d;
  logic [BEEP_W-1:0] beep_q, beep_d;
  logic              buzzer_q, buzzer_d;
  logic              tick, match, trigger, ring_buzz;

  always_comb begin
    tick    = (presc_q == PRE_LAST);
    presc_d = tick ? '0 : presc_q + PRE_W'(1);
    match   = ({bus.HOUR_TEN, bus.HOUR_ONE, bus.MIN_TEN, bus.MIN_ONE} ==
                {bus.A_HOUR_TEN, bus.A_HOUR_ONE, bus.A_MIN_TEN, bus.A_MIN_ONE}) &&
              (bus.SEC_TEN == 4'd0) && (bus.SEC_ONE == 4'd0);
    match_hist_d = match;
    trigger = match && !match_hist_q && bus.ALARM_ON && !bus.SET_ALARM;
  end

  // Ring and snooze timers count down to zero; the tick at zero ends the phase.
  always_comb begin
    state_d      = state_q;
    snooze_cnt_d = snooze_cnt_q;
    ring_d       = ring_q;
    snz_d        = snz_q;
    beep_d       = (beep_q == BEEP_LAST) ? '0 : beep_q + BEEP_W'(1);
    if (!bus.ALARM_ON) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF: state_d = ST_ARMED;
        ST_ARMED: begin
          if (trigger) begin
            state_d      = ST_RINGING;
            snooze_cnt_d = 2'd0;
            ring_d       = RING_LAST;
            beep_d       = '0;
          end
        end
        ST_RINGING: begin
          if (bus.SET_ALARM || bus.DISMISS) begin
            state_d = ST_ARMED;
          end else if (bus.SNOOZE) begin
            if (snooze_cnt_q < SNZ_MAX) begin
              state_d      = ST_SNOOZE;
              snooze_cnt_d = snooze_cnt_q + 2'd1;
              snz_d        = SNZ_LAST;
            end else begin
              state_d = ST_ARMED;
            end
          end else if (tick) begin
            if (ring_q == '0) state_d = ST_ARMED;
            else ring_d = ring_q - RING_W'(1);
          end
        end
        default: begin
          if (bus.SET_ALARM || bus.DISMISS) begin
            state_d = ST_ARMED;
          end else if (tick) begin
            if (snz_q == '0) begin
              state_d = ST_RINGING;
              ring_d  = RING_LAST;
              beep_d  = '0;
            end else begin
              snz_d = snz_q - SNZ_W'(1);
            end
          end
        end
      endcase
    end
    ring_buzz = (state_d == ST_RINGING) && (beep_d < BEEP_ON);
  end

`ifdef HOURLY_CHIME_EN
  localparam int CHIME_W = $clog2(CHIME_CYC + 1);

  logic               hour_hist_q, hour_hist_d;
  logic [CHIME_W-1:0] chime_q, chime_d;
  logic               top_of_hour;

  always_comb begin
    top_of_hour = (bus.MIN_TEN == 4'd0) && (bus.MIN_ONE == 4'd0) &&
                  (bus.SEC_TEN == 4'd0) && (bus.SEC_ONE == 4'd0);
    hour_hist_d = top_of_hour;
    chime_d     = (chime_q != '0) ? chime_q - CHIME_W'(1) : '0;
    if (bus.SET_ALARM || (state_d == ST_RINGING) ||
        !((state_q == ST_OFF) || (state_q == ST_ARMED))) begin
      chime_d = '0;
    end else if (top_of_hour && !hour_hist_q) begin
      chime_d = CHIME_W'(CHIME_CYC);
    end
    buzzer_d = ring_buzz || (chime_d != '0);
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      hour_hist_q <= 1'b1;
      chime_q     <= '0;
    end else begin
      hour_hist_q <= hour_hist_d;
      chime_q     <= chime_d;
    end
  end
`else
  always_comb buzzer_d = ring_buzz;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      presc_q      <= '0;
      match_hist_q <= 1'b1;
      state_q      <= ST_OFF;
      snooze_cnt_q <= 2'd0;
      ring_q       <= '0;
      snz_q        <= '0;
      beep_q       <= '0;
      buzzer_q     <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      match_hist_q <= match_hist_d;
      state_q      <= state_d;
      snooze_cnt_q <= snooze_cnt_d;
      ring_q       <= ring_d;
      snz_q        <= snz_d;
      beep_q       <= beep_d;
      buzzer_q     <= buzzer_d;
    end
  end

  assign bus.BUZZER      = buzzer_q;
  assign bus.ALARM_STATE = state_q;
  assign bus.SNOOZE_CNT  = snooze_cnt_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed bench for alarm_sequencer: vector table plus multi-cycle sequences.
module tb_alarm_sequencer;
  localparam int CLK_HZ = 20, BEEP_HALF = 5, RING_SEC = 4;
  localparam int SNOOZE_SEC = 3, MAX_SNOOZE = 2, CHIME_CYC = 6;
  localparam logic [1:0] S_OFF = 2'd0, S_ARM = 2'd1, S_RING = 2'd2, S_SNZ = 2'd3;

  typedef struct {
    logic        rst, on, set, snz, dis;
    logic [23:0] tm;
    logic [1:0]  st;
    logic        bz;
    logic [1:0]  cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alarm_sequencer_if bus();
  alarm_sequencer #(
    .CLK_HZ(CLK_HZ), .BEEP_HALF(BEEP_HALF), .RING_SEC(RING_SEC),
    .SNOOZE_SEC(SNOOZE_SEC), .MAX_SNOOZE(MAX_SNOOZE), .CHIME_CYC(CHIME_CYC)
  ) dut (.CLOCK_50(clk), .RESET(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  int presc_m = 0;
  bit tick_m = 1'b0;
  vec_t vecs[21];

  function automatic vec_t mk(input logic r, input logic o, input logic s,
                              input logic sn, input logic d, input logic [23:0] t,
                              input logic [1:0] st, input logic bz, input logic [1:0] c);
    vec_t v;
    v.rst = r; v.on = o; v.set = s; v.snz = sn; v.dis = d; v.tm = t;
    v.st = st; v.bz = bz; v.cnt = c;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [1:0] st, input logic bz,
                           input logic [1:0] cnt);
    chk({name, ".state"}, 32'(bus.ALARM_STATE), 32'(st));
    chk({name, ".buzzer"}, 32'(bus.BUZZER), 32'(bz));
    chk({name, ".snooze_cnt"}, 32'(bus.SNOOZE_CNT), 32'(cnt));
  endtask

  // Advances one edge; tick_m tells whether that edge carried a 1 s tick.
  task automatic step();
    tick_m  = !rst && (presc_m == CLK_HZ - 1);
    presc_m = rst ? 0 : ((presc_m == CLK_HZ - 1) ? 0 : presc_m + 1);
    @(posedge clk);
    #1;
  endtask

  task automatic set_time(input logic [23:0] t);
    {bus.HOUR_TEN, bus.HOUR_ONE, bus.MIN_TEN, bus.MIN_ONE, bus.SEC_TEN, bus.SEC_ONE} = t;
  endtask

  task automatic pulse(input logic snz, input logic dis);
    bus.SNOOZE = snz; bus.DISMISS = dis;
    step();
    bus.SNOOZE = 1'b0; bus.DISMISS = 1'b0;
  endtask

  task automatic fire(input string name, input logic [1:0] cnt);
    set_time(24'h072959); step();
    set_time(24'h073000); step();
    check_out(name, S_RING, 1'b1, cnt);
  endtask

  task automatic wait_ticks(input string name, input int ticks, input logic [1:0] during,
                            input logic [1:0] after);
    int seen = 0;
    bit done = 1'b0;
    for (int i = 0; i < CLK_HZ * (ticks + 1) + 5 && !done; i++) begin
      step();
      if (tick_m) seen++;
      if (seen == ticks) begin
        done = 1'b1;
        chk({name, ".end_state"}, 32'(bus.ALARM_STATE), 32'(after));
      end else if (bus.ALARM_STATE !== during) begin
        chk({name, ".hold_state"}, 32'(bus.ALARM_STATE), 32'(during));
      end
    end
    chk({name, ".reached"}, 32'(done), 32'd1);
  endtask

  initial begin
    bus.ALARM_ON = 1'b1; bus.SET_ALARM = 1'b0; bus.SNOOZE = 1'b0; bus.DISMISS = 1'b0;
    {bus.A_HOUR_TEN, bus.A_HOUR_ONE, bus.A_MIN_TEN, bus.A_MIN_ONE} = 16'h0730;
    set_time(24'h073000);

    //          rst on set snz dis time        state   bz cnt
    vecs[0]  = mk(1, 1, 0, 0, 0, 24'h073000, S_OFF,  0, 0);
    vecs[1]  = mk(0, 1, 0, 0, 0, 24'h073000, S_ARM,  0, 0);
    vecs[2]  = mk(0, 1, 0, 0, 0, 24'h073000, S_ARM,  0, 0);
    vecs[3]  = mk(0, 1, 0, 0, 0, 24'h072959, S_ARM,  0, 0);
    vecs[4]  = mk(0, 1, 0, 0, 0, 24'h073000, S_RING, 1, 0);
    vecs[5]  = mk(0, 1, 0, 0, 0, 24'h073000, S_RING, 1, 0);
    vecs[6]  = mk(0, 1, 0, 0, 0, 24'h073000, S_RING, 1, 0);
    vecs[7]  = mk(0, 1, 0, 0, 0, 24'h073000, S_RING, 1, 0);
    vecs[8]  = mk(0, 1, 0, 0, 0, 24'h073000, S_RING, 1, 0);
    vecs[9]  = mk(0, 1, 0, 0, 0, 24'h073000, S_RING, 0, 0);
    vecs[10] = mk(0, 1, 0, 1, 0, 24'h073000, S_SNZ,  0, 1);
    vecs[11] = mk(0, 1, 0, 1, 0, 24'h073000, S_SNZ,  0, 1);
    vecs[12] = mk(0, 1, 0, 0, 1, 24'h073000, S_ARM,  0, 1);
    vecs[13] = mk(0, 1, 0, 0, 0, 24'h072959, S_ARM,  0, 1);
    vecs[14] = mk(0, 1, 1, 0, 0, 24'h073000, S_ARM,  0, 1);
    vecs[15] = mk(0, 1, 0, 0, 0, 24'h073000, S_ARM,  0, 1);
    vecs[16] = mk(0, 1, 0, 0, 0, 24'h072959, S_ARM,  0, 1);
    vecs[17] = mk(0, 1, 0, 0, 0, 24'h073000, S_RING, 1, 0);
    vecs[18] = mk(0, 1, 0, 1, 1, 24'h073000, S_ARM,  0, 0);
    vecs[19] = mk(0, 0, 0, 0, 0, 24'h073000, S_OFF,  0, 0);
    vecs[20] = mk(1, 1, 0, 1, 0, 24'h073000, S_OFF,  0, 0);

    for (int i = 0; i < 21; i++) begin
      rst = vecs[i].rst; bus.ALARM_ON = vecs[i].on; bus.SET_ALARM = vecs[i].set;
      bus.SNOOZE = vecs[i].snz; bus.DISMISS = vecs[i].dis; set_time(vecs[i].tm);
      step();
      check_out($sformatf("vec%0d", i), vecs[i].st, vecs[i].bz, vecs[i].cnt);
    end
    rst = 1'b0; bus.SNOOZE = 1'b0; bus.ALARM_ON = 1'b1;

    // Full ring: 5-on/5-off beep pattern until the RING_SEC-th tick times out.
    set_time(24'h072959); step();
    check_out("seqa_armed", S_ARM, 1'b0, 2'd0);
    set_time(24'h073000); step();
    check_out("seqa_entry", S_RING, 1'b1, 2'd0);
    begin
      int n = 0, secs = 0;
      bit done = 1'b0;
      for (int i = 0; i < CLK_HZ * (RING_SEC + 1) && !done; i++) begin
        step(); n++;
        if (tick_m) secs++;
        if (secs == RING_SEC) begin
          done = 1'b1;
          check_out("seqa_timeout", S_ARM, 1'b0, 2'd0);
        end else begin
          if (bus.ALARM_STATE !== S_RING) chk("seqa_ring_state", 32'(bus.ALARM_STATE), 32'(S_RING));
          if (bus.BUZZER !== ((n % (2 * BEEP_HALF)) < BEEP_HALF))
            chk($sformatf("seqa_beep_n%0d", n), 32'(bus.BUZZER),
                32'((n % (2 * BEEP_HALF)) < BEEP_HALF));
        end
      end
      chk("seqa_timeout_reached", 32'(done), 32'd1);
    end
    repeat (5) step();
    check_out("seqa_no_retrigger", S_ARM, 1'b0, 2'd0);

    // Snooze cycling up to the limit; the extra snooze acts as dismiss.
    fire("seqb_fire", 2'd0);
    pulse(1'b1, 1'b0);
    check_out("seqb_snz1", S_SNZ, 1'b0, 2'd1);
    wait_ticks("seqb_rering1", SNOOZE_SEC, S_SNZ, S_RING);
    check_out("seqb_rering1_out", S_RING, 1'b1, 2'd1);
    pulse(1'b1, 1'b0);
    check_out("seqb_snz2", S_SNZ, 1'b0, 2'd2);
    wait_ticks("seqb_rering2", SNOOZE_SEC, S_SNZ, S_RING);
    pulse(1'b1, 1'b0);
    check_out("seqb_snz_limit", S_ARM, 1'b0, 2'd2);
    fire("seqb_fire2", 2'd0);
    pulse(1'b1, 1'b0);
    wait_ticks("seqb_rering3", SNOOZE_SEC, S_SNZ, S_RING);
    pulse(1'b1, 1'b1);
    check_out("seqb_snz_and_dis", S_ARM, 1'b0, 2'd1);

    // Switch-off from snooze, SET_ALARM and DISMISS while ringing.
    fire("seqc_fire", 2'd0);
    pulse(1'b1, 1'b0);
    bus.ALARM_ON = 1'b0; step();
    check_out("seqc_off_from_snz", S_OFF, 1'b0, 2'd1);
    bus.ALARM_ON = 1'b1; step();
    check_out("seqc_rearm", S_ARM, 1'b0, 2'd1);
    fire("seqc_fire2", 2'd0);
    bus.SET_ALARM = 1'b1; step(); bus.SET_ALARM = 1'b0;
    check_out("seqc_set_alarm", S_ARM, 1'b0, 2'd0);
    fire("seqc_fire3", 2'd0);
    pulse(1'b0, 1'b1);
    check_out("seqc_dismiss", S_ARM, 1'b0, 2'd0);

    // Top-of-hour chime only exists in the chime build.
    set_time(24'h085959); step();
    set_time(24'h090000);
    begin
      int hc = 0;
      for (int i = 0; i < CHIME_CYC + 6; i++) begin
        step();
        if (bus.BUZZER === 1'b1) hc++;
      end
`ifdef HOURLY_CHIME_EN
      chk("seqd_chime_cycles", 32'(hc), 32'(CHIME_CYC));
`else
      chk("seqd_chime_cycles", 32'(hc), 32'd0);
`endif
    end
    check_out("seqd_state", S_ARM, 1'b0, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
